// File: rtl/w_writeback_grf.sv
// W-stage write-back: result select, load extension,
// 32x32 register file with bypass, retire counter.
module w_writeback_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteW,
  input  logic [1:0]  MemtoRegW,
  input  logic [31:0] RDW,
  input  logic [31:0] ALUoutW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] PC_4W,
  input  logic [31:0] ext_immW,
  input  logic [1:0]  TnewW,
  input  logic [2:0]  LoadTypeW,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WDW,
  output logic        FwdValidW,
  output logic [31:0] retire_cnt
);

  logic [31:0] regs [32];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        wr_req;
  logic        commit;

  assign wr_req = RegWriteW && (WriteRegW != 5'd0);
  assign commit = reset && wr_req;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    byte_sel = RDW[7:0];
    unique case (ALUoutW[1:0])
      2'b00: byte_sel = RDW[7:0];
      2'b01: byte_sel = RDW[15:8];
      2'b10: byte_sel = RDW[23:16];
      2'b11: byte_sel = RDW[31:24];
      default: byte_sel = RDW[7:0];
    endcase
    half_sel = ALUoutW[1] ? RDW[31:16] : RDW[15:0];
  end

  // Extend load data by width and signedness.
  always_comb begin
    load_data = RDW;
    case (LoadTypeW)
      3'b001: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010: load_data = {24'd0, byte_sel};
      3'b011: load_data = {{16{half_sel[15]}}, half_sel};
      3'b100: load_data = {16'd0, half_sel};
      default: load_data = RDW;
    endcase
  end

  // Final write-back value mux.
  always_comb begin
    WDW = ALUoutW;
    unique case (MemtoRegW)
      2'b00: WDW = ALUoutW;
      2'b01: WDW = load_data;
      2'b10: WDW = PC_4W + 32'd4;
      2'b11: WDW = ext_immW;
      default: WDW = ALUoutW;
    endcase
  end

  assign FwdValidW = wr_req && (TnewW == 2'd0);

  // Read ports with same-cycle write bypass.
  always_comb begin
    if (A1 == 5'd0)
      RD1 = 32'd0;
    else if (wr_req && (WriteRegW == A1))
      RD1 = WDW;
    else
      RD1 = regs[A1];
    if (A2 == 5'd0)
      RD2 = 32'd0;
    else if (wr_req && (WriteRegW == A2))
      RD2 = WDW;
    else
      RD2 = regs[A2];
  end

  // Register file and retire counter update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'd0;
      retire_cnt <= 32'd0;
    end else if (commit) begin
      regs[WriteRegW] <= WDW;
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule
